// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline stall/flush sequencer
package pipeline_ctrl_pkg;

    localparam int DEF_REG_AW   = 5;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } en_t;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic memwb;
    } fl_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: flags a load in EX whose nonzero destination feeds a source read in ID
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              load_use
);

    always_comb
        load_use = ex_memread && (ex_rd != '0) &&
                   ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline (load-use, squash,
// memory-wait freeze with watchdog, halt drain); enables and flushes are Mealy outputs
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              id_halt,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_flush,
    output logic              halted,
    output logic              mem_timeout,
    output logic [15:0]       stall_count
);

    localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT - 1);
    localparam logic [1:0]    DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    state_t        state, state_d;
    logic [WW-1:0] wait_cnt, wait_d;
    logic [1:0]    drain_cnt, drain_d;
    logic          tmo_d;
    logic [15:0]   stall_d;
    logic          load_use, mem_wait;
    en_t           en;
    fl_t           fl;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    assign mem_wait = mem_req && !mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            drain_cnt   <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            state       <= state_d;
            wait_cnt    <= wait_d;
            drain_cnt   <= drain_d;
            mem_timeout <= tmo_d;
            stall_count <= stall_d;
        end
    end

    always_comb begin
        state_d = state;
        drain_d = drain_cnt;
        wait_d  = '0;
        tmo_d   = mem_timeout;
        if (state != HALTED) begin
            if (mem_wait) begin
                wait_d = wait_cnt + 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    state_d = HALTED;
                    tmo_d   = 1'b1;
                end
            end else if (state == DRAIN) begin
                drain_d = drain_cnt + 2'd1;
                state_d = (drain_cnt == DRAIN_LAST) ? HALTED : DRAIN;
            end else if (!ex_branch_taken && !load_use && id_halt) begin
                state_d = DRAIN;
                drain_d = 2'd0;
            end
        end
        stall_d = (!en.pc && state != HALTED && stall_count != 16'hFFFF) ?
                  stall_count + 16'd1 : stall_count;
    end

    // DRAIN keeps the PC frozen and feeds bubbles behind the halt, even under a branch
    always_comb begin
        en = '1;
        fl = '0;
        if (!reset || state == HALTED) begin
            en = '0;
        end else if (mem_wait) begin
            en = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b0, memwb: 1'b1};
            fl.memwb = 1'b1;
        end else begin
            if (ex_branch_taken) begin
                fl.ifid = 1'b1;
                fl.idex = 1'b1;
            end else if (state == RUN && load_use) begin
                en.pc   = 1'b0;
                en.ifid = 1'b0;
                fl.idex = 1'b1;
            end else if (state == RUN && id_halt) begin
                en.pc   = 1'b0;
                fl.ifid = 1'b1;
            end
            if (state == DRAIN) begin
                en.pc   = 1'b0;
                fl.ifid = 1'b1;
            end
        end
    end

    assign pc_en       = en.pc;
    assign ifid_en     = en.ifid;
    assign idex_en     = en.idex;
    assign exmem_en    = en.exmem;
    assign memwb_en    = en.memwb;
    assign ifid_flush  = fl.ifid;
    assign idex_flush  = fl.idex;
    assign memwb_flush = fl.memwb;
    assign halted      = reset && state == HALTED;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors with hand-computed expectations for pipeline_ctrl
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_memread = 1'b0;
    logic       ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0, id_halt = 1'b0;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, memwb_flush, halted, mem_timeout;
    logic [15:0] stall_count;
    logic [9:0] outs;
    int         n_tests = 0;
    int         n_fail = 0;

    // {pc,ifid,idex,exmem,memwb enables, ifid,idex,memwb flushes, halted, mem_timeout}
    localparam logic [9:0] IDLE   = 10'b11111_000_00;
    localparam logic [9:0] LDUSE  = 10'b00111_010_00;
    localparam logic [9:0] BRANCH = 10'b11111_110_00;
    localparam logic [9:0] MWAIT  = 10'b00001_001_00;
    localparam logic [9:0] DRN    = 10'b01111_100_00;
    localparam logic [9:0] HALT   = 10'b00000_000_10;
    localparam logic [9:0] TMO    = 10'b00000_000_11;

    pipeline_ctrl #(.REG_AW(5), .MEM_TIMEOUT(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .id_halt         (id_halt),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_flush     (memwb_flush),
        .halted          (halted),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count)
    );

    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, memwb_flush, halted, mem_timeout};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        {id_rs, id_rt, ex_rd} = '0;
        {id_uses_rs, id_uses_rt, ex_memread, ex_branch_taken, mem_req, mem_ready, id_halt} = '0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_outs"}, 16'(outs), 16'h0);
        chk({tag, "_cnt"}, stall_count, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        do_reset("rst0");
        @(negedge clk); chk("idle", 16'(outs), 16'(IDLE));
        cyc();

        ex_memread = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
        @(negedge clk); chk("lu_rs", 16'(outs), 16'(LDUSE));
        cyc(); clear_in();
        @(negedge clk); chk("lu_after", 16'(outs), 16'(IDLE));
        chk("lu_cnt", stall_count, 16'd1);
        cyc();

        ex_memread = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
        @(negedge clk); chk("lu_r0", 16'(outs), 16'(IDLE));
        cyc();
        ex_rd = 5; id_rs = 5; id_uses_rs = 0;
        @(negedge clk); chk("lu_nouse", 16'(outs), 16'(IDLE));
        cyc();
        id_rt = 5; id_uses_rt = 1;
        @(negedge clk); chk("lu_rt", 16'(outs), 16'(LDUSE));
        cyc(); clear_in();
        chk("lu_cnt2", stall_count, 16'd2);

        ex_branch_taken = 1; ex_memread = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1; id_halt = 1;
        @(negedge clk); chk("br_all", 16'(outs), 16'(BRANCH));
        cyc(); clear_in();
        @(negedge clk); chk("br_run", 16'(outs), 16'(IDLE));
        chk("br_cnt", stall_count, 16'd2);
        cyc();

        mem_req = 1; mem_ready = 1;
        @(negedge clk); chk("mem_zero", 16'(outs), 16'(IDLE));
        cyc();
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("mem_wait", 16'(outs), 16'(MWAIT));
            cyc();
        end
        mem_ready = 1;
        @(negedge clk); chk("mem_rel", 16'(outs), 16'(IDLE));
        chk("mem_cnt", stall_count, 16'd5);
        cyc(); clear_in();

        id_halt = 1;
        @(negedge clk); chk("halt_n", 16'(outs), 16'(DRN));
        cyc(); clear_in();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); chk("drain", 16'(outs), 16'(DRN));
            cyc();
        end
        @(negedge clk); chk("halt_n4", 16'(outs), 16'(HALT));
        chk("halt_cnt", stall_count, 16'd9);
        ex_branch_taken = 1; mem_req = 1;
        repeat (3) cyc();
        @(negedge clk); chk("halt_hold", 16'(outs), 16'(HALT));
        chk("halt_cnt2", stall_count, 16'd9);
        clear_in();

        do_reset("rst1");
        id_halt = 1;
        @(negedge clk); chk("hw_n", 16'(outs), 16'(DRN));
        cyc(); clear_in();
        @(negedge clk); chk("hw_n1", 16'(outs), 16'(DRN));
        cyc(); mem_req = 1;
        @(negedge clk); chk("hw_wait", 16'(outs), 16'(MWAIT));
        cyc(); clear_in();
        @(negedge clk); chk("hw_n3", 16'(outs), 16'(DRN));
        cyc();
        @(negedge clk); chk("hw_n4", 16'(outs), 16'(DRN));
        cyc();
        @(negedge clk); chk("hw_n5", 16'(outs), 16'(HALT));
        chk("hw_cnt", stall_count, 16'd5);
        cyc();

        do_reset("rst2");
        id_halt = 1;
        cyc(); clear_in();
        @(negedge clk); chk("rd_drain", 16'(outs), 16'(DRN));
        cyc();
        do_reset("rst_drain");
        @(negedge clk); chk("rd_run", 16'(outs), 16'(IDLE));
        cyc();
        @(negedge clk); chk("rd_run2", 16'(outs), 16'(IDLE));
        cyc();

        do_reset("rst3");
        mem_req = 1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); chk("tmo_wait", 16'(outs), 16'(MWAIT));
            cyc();
        end
        @(negedge clk); chk("tmo_fire", 16'(outs), 16'(TMO));
        chk("tmo_cnt", stall_count, 16'd16);
        clear_in();
        repeat (3) cyc();
        @(negedge clk); chk("tmo_hold", 16'(outs), 16'(TMO));
        cyc();
        do_reset("rst4");
        @(negedge clk); chk("tmo_clr", 16'(outs), 16'(IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
